shift_issue_stage: RTL and testbench

- Pipeline stage directly upstream of the ALU barrel shifter.
- Accepts DLX shift instructions and their register operands over a valid/ready handshake, and decodes direction, type and amount.
- Presents registered operand, amount word and 2-bit shift control to the shifter through a 2-entry skid buffer, so back-pressure never drops or duplicates an instruction.
- Output format matches the shifter inputs exactly: a[0:31], b[0:31], ctrl[0:1].

---
 rtl/shift_issue_stage_pkg.sv | 49 ++++
 rtl/shift_issue_stage_if.sv | 37 +++
 rtl/shift_issue_stage_decode.sv | 79 +++++++
 rtl/shift_issue_stage.sv | 118 +++++++++++
 tb/tb_shift_issue_stage.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/shift_issue_stage_pkg.sv
// ============================================================================
// Module   : shift_pkg
// Brief    : Shared constants, payload type and state encoding for the shift
//            issue stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_pkg;

    localparam int XLEN  = 32;
    localparam int AMT_W = 5;

    // Opcode / funct encodings of the DLX shift instructions
    localparam logic [0:5] OP_RTYPE = 6'h00;
    localparam logic [0:5] F_SLL    = 6'h04;
    localparam logic [0:5] F_SRL    = 6'h06;
    localparam logic [0:5] F_SRA    = 6'h07;
    localparam logic [0:5] OP_SLLI  = 6'h14;
    localparam logic [0:5] OP_SRLI  = 6'h16;
    localparam logic [0:5] OP_SRAI  = 6'h17;

    // ctrl[0]: 1 = right, ctrl[1]: 1 = arithmetic
    localparam logic [0:1] CTRL_SLL = 2'b00;
    localparam logic [0:1] CTRL_SRL = 2'b10;
    localparam logic [0:1] CTRL_SRA = 2'b11;

    typedef struct packed {
        logic [0:XLEN-1]  a;
        logic [0:AMT_W-1] amt;
        logic [0:1]       ctrl;
        logic [0:4]       rd;
        logic             illegal;
    } shift_payload_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_t;

    // Shifter b port: amount right-justified, upper bits zero
    function automatic logic [0:XLEN-1] amt_word(input logic [0:AMT_W-1] amt);
        return {{(XLEN-AMT_W){1'b0}}, amt};
    endfunction

endpackage

`default_nettype wire

// File: rtl/shift_issue_stage_if.sv
// ============================================================================
// Module   : shift_issue_stage_if
// Brief    : Upstream issue and downstream shifter handshake/payload bundle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface shift_issue_stage_if;
    import shift_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [0:XLEN-1] instr;
    logic [0:XLEN-1] rs1_val;
    logic [0:XLEN-1] rs2_val;
    logic            out_valid;
    logic            out_ready;
    logic [0:XLEN-1] shift_a;
    logic [0:XLEN-1] shift_b;
    logic [0:1]      shift_ctrl;
    logic [0:4]      rd;
    logic            illegal;

    // master: the environment around the stage (issue side + shifter side)
    modport master (
        output in_valid, instr, rs1_val, rs2_val, out_ready,
        input  in_ready, out_valid, shift_a, shift_b, shift_ctrl, rd, illegal
    );

    modport slave (
        input  in_valid, instr, rs1_val, rs2_val, out_ready,
        output in_ready, out_valid, shift_a, shift_b, shift_ctrl, rd, illegal
    );

endinterface

`default_nettype wire

// File: rtl/shift_issue_stage_decode.sv
// ============================================================================
// Module   : shift_decode
// Brief    : Combinational decode of a DLX shift instruction into the shifter
//            payload. Optional macro SHIFT_AMT_SAT_EN saturates register-form
//            amounts whose upper rs2 bits are non-zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_decode
    import shift_pkg::*;
(
    input  wire logic [0:XLEN-1] instr,
    input  wire logic [0:XLEN-1] rs1_val,
    input  wire logic [0:XLEN-1] rs2_val,
    output shift_payload_t       payload
);

    logic [0:5] w_opcode;
    logic [0:5] w_funct;
    logic       w_is_rtype_shift;
    logic       w_is_itype_shift;
    logic       w_unused_bits;

    assign w_opcode = instr[0:5];
    assign w_funct  = instr[26:31];

    assign w_is_rtype_shift = (w_opcode == OP_RTYPE) &&
                              ((w_funct == F_SLL) || (w_funct == F_SRL) || (w_funct == F_SRA));
    assign w_is_itype_shift = (w_opcode == OP_SLLI) || (w_opcode == OP_SRLI) ||
                              (w_opcode == OP_SRAI);

    always_comb begin
        payload         = '0;
        payload.a       = rs1_val;
        payload.illegal = 1'b1;

        if (w_is_rtype_shift) begin
            payload.illegal = 1'b0;
            payload.rd      = instr[16:20];
            payload.amt     = rs2_val[27:31];
            case (w_funct)
                F_SLL:   payload.ctrl = CTRL_SLL;
                F_SRL:   payload.ctrl = CTRL_SRL;
                default: payload.ctrl = CTRL_SRA;
            endcase
`ifdef SHIFT_AMT_SAT_EN
            // Amount >= 32: logical shifts flush to zero, SRA fills with sign
            if (|rs2_val[0:26]) begin
                if (payload.ctrl == CTRL_SRA) begin
                    payload.amt = '1;
                end else begin
                    payload.a   = '0;
                    payload.amt = '0;
                end
            end
`endif
        end else if (w_is_itype_shift) begin
            payload.illegal = 1'b0;
            payload.rd      = instr[11:15];
            payload.amt     = instr[27:31];
            case (w_opcode)
                OP_SLLI: payload.ctrl = CTRL_SLL;
                OP_SRLI: payload.ctrl = CTRL_SRL;
                default: payload.ctrl = CTRL_SRA;
            endcase
        end
    end

    // Register-source fields and the R-type shamt field play no part in decode
`ifdef SHIFT_AMT_SAT_EN
    assign w_unused_bits = ^{instr[6:10], instr[21:25]};
`else
    assign w_unused_bits = ^{instr[6:10], instr[21:25], rs2_val[0:26]};
`endif

endmodule

`default_nettype wire

// File: rtl/shift_issue_stage.sv
// ============================================================================
// Module   : shift_issue_stage
// Brief    : Shift issue stage: decodes shift instructions and feeds the barrel
//            shifter through a 2-entry skid buffer. Optional macro
//            SHIFT_AMT_SAT_EN enables register-amount saturation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_issue_stage
    import shift_pkg::*;
(
    input  wire logic           clk,
    input  wire logic           rst_n,
    input  wire logic           flush,
    shift_issue_stage_if.slave  bus
);

    skid_state_t    r_state;
    skid_state_t    w_next_state;
    shift_payload_t w_dec;
    shift_payload_t r_head;
    shift_payload_t r_skid;
    logic           r_in_ready;
    logic           w_accept;
    logic           w_drain;
    logic           w_load_head;
    logic           w_load_skid;
    logic           w_skid_to_head;

    shift_decode u_decode (
        .instr   (bus.instr),
        .rs1_val (bus.rs1_val),
        .rs2_val (bus.rs2_val),
        .payload (w_dec)
    );

    assign w_accept = bus.in_valid && r_in_ready;
    assign w_drain  = (r_state != ST_EMPTY) && bus.out_ready;

    always_comb begin
        w_next_state   = r_state;
        w_load_head    = 1'b0;
        w_load_skid    = 1'b0;
        w_skid_to_head = 1'b0;

        if (flush) begin
            w_next_state = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_next_state = ST_ONE;
                        w_load_head  = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_drain) begin
                        w_load_head  = 1'b1;
                    end else if (w_accept) begin
                        w_next_state = ST_TWO;
                        w_load_skid  = 1'b1;
                    end else if (w_drain) begin
                        w_next_state = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only a drain can occur
                    if (w_drain) begin
                        w_next_state   = ST_ONE;
                        w_skid_to_head = 1'b1;
                    end
                end
                default: begin
                    w_next_state = ST_EMPTY;
                end
            endcase
        end
    end

    // in_ready follows the next state so out_ready never reaches it combinationally
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_next_state;
            r_in_ready <= (w_next_state != ST_TWO);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_head) begin
                r_head <= w_dec;
            end else if (w_skid_to_head) begin
                r_head <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_dec;
            end
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.out_valid  = (r_state != ST_EMPTY);
    assign bus.shift_a    = r_head.a;
    assign bus.shift_b    = amt_word(r_head.amt);
    assign bus.shift_ctrl = r_head.ctrl;
    assign bus.rd         = r_head.rd;
    assign bus.illegal    = r_head.illegal;

endmodule

`default_nettype wire

// File: tb/tb_shift_issue_stage.sv
// ============================================================================
// Module   : tb_shift_issue_stage
// Brief    : Directed + random bench for shift_issue_stage against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_issue_stage;

    typedef struct packed {
        logic [31:0] a;
        logic [4:0]  amt;
        logic [1:0]  ctrl;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    shift_issue_stage_if bus ();

    shift_issue_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus.slave)
    );

    // Expected shifter payload, straight from the instruction-set rules
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] r1,
                                   input logic [31:0] r2);
        exp_t       e;
        logic [5:0] op;
        logic [5:0] fn;
        op = ins[31:26];
        fn = ins[5:0];
        e.a = r1; e.amt = 5'd0; e.ctrl = 2'b00; e.rd = 5'd0; e.ill = 1'b1;
        if (op == 6'h00 && (fn == 6'h04 || fn == 6'h06 || fn == 6'h07)) begin
            e.ill  = 1'b0;
            e.rd   = ins[15:11];
            e.amt  = r2[4:0];
            e.ctrl = (fn == 6'h04) ? 2'b00 : (fn == 6'h06) ? 2'b10 : 2'b11;
`ifdef SHIFT_AMT_SAT_EN
            if (r2 > 32'd31) begin
                if (fn == 6'h07) e.amt = 5'd31;
                else begin e.amt = 5'd0; e.a = 32'd0; end
            end
`endif
        end else if (op == 6'h14 || op == 6'h16 || op == 6'h17) begin
            e.ill  = 1'b0;
            e.rd   = ins[20:16];
            e.amt  = ins[4:0];
            e.ctrl = (op == 6'h14) ? 2'b00 : (op == 6'h16) ? 2'b10 : 2'b11;
        end
        return e;
    endfunction

    function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] rdv);
        return {6'h00, 5'd1, 5'd2, rdv, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rdv,
                                          input logic [15:0] imm);
        return {op, 5'd1, rdv, imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock: compare against the model at negedge, then advance the model
    task automatic step();
        bit acc;
        bit drn;
        @(negedge clk);
        chk("out_valid", bus.out_valid, q.size() > 0);
        chk("in_ready", bus.in_ready, q.size() < 2);
        if (q.size() > 0) begin
            chk("shift_a", bus.shift_a, q[0].a);
            chk("shift_b", bus.shift_b, {27'd0, q[0].amt});
            chk("shift_ctrl", bus.shift_ctrl, q[0].ctrl);
            chk("illegal", bus.illegal, q[0].ill);
            if (!q[0].ill) chk("rd", bus.rd, q[0].rd);
        end
        acc = bus.in_valid && (q.size() < 2);
        drn = (q.size() > 0) && bus.out_ready;
        @(posedge clk);
        if (!rst_n || flush) begin
            q.delete();
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(model(bus.instr, bus.rs1_val, bus.rs2_val));
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] r1,
                         input logic [31:0] r2, input logic ordy);
        bus.in_valid  = v;
        bus.instr     = ins;
        bus.rs1_val   = r1;
        bus.rs2_val   = r2;
        bus.out_ready = ordy;
    endtask

    initial begin
        logic [31:0] rins;
        logic [31:0] rr2;
        int          kind;

        // Reset held two cycles with a pending input
        drive(1'b1, itype(6'h17, 5'd3, 16'd4), 32'h1234_5678, 32'd0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 32'd0);
        chk("rst_in_ready", bus.in_ready, 32'd1);
        chk("rst_shift_a", bus.shift_a, 32'd0);
        chk("rst_shift_b", bus.shift_b, 32'd0);
        chk("rst_ctrl", bus.shift_ctrl, 32'd0);
        chk("rst_rd", bus.rd, 32'd0);
        chk("rst_illegal", bus.illegal, 32'd0);
        q.delete();
        rst_n = 1'b1;

        // SRAI by 4
        drive(1'b1, itype(6'h17, 5'd7, 16'd4), 32'h8000_0010, 32'd0, 1'b1);
        step();
        chk("srai_valid", bus.out_valid, 32'd1);
        chk("srai_ctrl", bus.shift_ctrl, 32'd3);
        chk("srai_b", bus.shift_b, 32'h0000_0004);
        chk("srai_a", bus.shift_a, 32'h8000_0010);
        chk("srai_illegal", bus.illegal, 32'd0);
        drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
        step();

        // Back-pressure: SLL then SRL with the shifter stalled
        drive(1'b1, rtype(6'h04, 5'd9), 32'hF0F0_0001, 32'd3, 1'b0);
        step();
        drive(1'b1, rtype(6'h06, 5'd10), 32'h0F0F_0002, 32'd1, 1'b0);
        step();
        chk("bp_in_ready", bus.in_ready, 32'd0);
        drive(1'b1, rtype(6'h07, 5'd11), 32'hDEAD_BEEF, 32'd5, 1'b0);
        step();
        chk("bp_hold_ctrl", bus.shift_ctrl, 32'd0);
        chk("bp_hold_b", bus.shift_b, 32'd3);
        drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
        step();
        chk("bp_second_ctrl", bus.shift_ctrl, 32'd2);
        chk("bp_second_b", bus.shift_b, 32'd1);
        step();
        chk("bp_drained", bus.out_valid, 32'd0);

        // Flush while full, with a simultaneous input offer
        drive(1'b1, rtype(6'h04, 5'd1), 32'd1, 32'd1, 1'b0);
        step();
        step();
        flush = 1'b1;
        drive(1'b1, itype(6'h14, 5'd2, 16'd7), 32'h5555_5555, 32'd0, 1'b0);
        step();
        flush = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
        chk("flush_valid", bus.out_valid, 32'd0);
        chk("flush_ready", bus.in_ready, 32'd1);
        step();
        chk("flush_no_deliver", bus.out_valid, 32'd0);

        // Non-shift R-type (ADD)
        drive(1'b1, rtype(6'h20, 5'd4), 32'hCAFE_0000, 32'd9, 1'b1);
        step();
        chk("add_illegal", bus.illegal, 32'd1);
        chk("add_ctrl", bus.shift_ctrl, 32'd0);
        chk("add_b", bus.shift_b, 32'd0);

        // Register-form SRA with an amount of 33
        drive(1'b1, rtype(6'h07, 5'd5), 32'h8000_0000, 32'h0000_0021, 1'b1);
        step();
`ifdef SHIFT_AMT_SAT_EN
        chk("sra_amt_sat", bus.shift_b, 32'h0000_001F);
`else
        chk("sra_amt_mod", bus.shift_b, 32'h0000_0001);
`endif
        drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
        step();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            kind = $urandom_range(0, 7);
            case (kind)
                0, 1, 2: rins = rtype((kind == 0) ? 6'h04 : (kind == 1) ? 6'h06 : 6'h07,
                                      5'($urandom));
                3, 4, 5: rins = itype((kind == 3) ? 6'h14 : (kind == 4) ? 6'h16 : 6'h17,
                                      5'($urandom), 16'($urandom));
                6:       rins = $urandom;
                default: rins = rtype(6'($urandom), 5'($urandom));
            endcase
            rr2 = ($urandom_range(0, 1) == 0) ? ($urandom & 32'h1F) : $urandom;
            drive(($urandom_range(0, 3) != 0), rins, $urandom, rr2,
                  ($urandom_range(0, 2) != 0));
            flush = ($urandom_range(0, 15) == 0);
            rst_n = ($urandom_range(0, 63) != 0);
            step();
        end
        flush = 1'b0;
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
